// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache-side state types
package cache_pkg;

    typedef enum logic [1:0] {
        CACHE_IDLE,
        CACHE_COMPARE,
        CACHE_WRITEBACK,
        CACHE_ALLOCATE
    } cache_state_t;

    // Memory-side responder sequencing for one line transfer.
    typedef enum logic [2:0] {
        LR_IDLE,
        LR_READ,
        LR_DRAIN,
        LR_WRITE,
        LR_ACK
    } line_resp_state_t;

endpackage

// File: rtl/cache_mem_responder_if.sv
// rtl/cache_mem_responder_if.sv - cache line request/ack bus
interface cache_mem_responder_if #(
    parameter int BYTE_NUM  = 8,
    parameter int ADDR_SIZE = 32
) ();
    logic                  rd_en;
    logic                  wr_en;
    logic [BYTE_NUM-1:0]   sel;
    logic [ADDR_SIZE-1:0]  addr;
    logic [8*BYTE_NUM-1:0] wr_data;
    logic [8*BYTE_NUM-1:0] rd_data;
    logic                  ack;

    modport master (
        output rd_en, wr_en, sel, addr, wr_data,
        input  rd_data, ack
    );

    modport slave (
        input  rd_en, wr_en, sel, addr, wr_data,
        output rd_data, ack
    );
endinterface

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - serves cache line refills/write-backs over a narrow SRAM
module cache_mem_responder
    import cache_pkg::*;
#(
    parameter int BYTE_NUM      = 8,
    parameter int BEAT_BYTES    = 2,
    parameter int ADDR_SIZE     = 32,
    parameter int RAM_ADDR_SIZE = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    cache_mem_responder_if.slave      line,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [RAM_ADDR_SIZE-1:0]  ram_addr,
    output logic [8*BEAT_BYTES-1:0]   ram_wdata,
    output logic [BEAT_BYTES-1:0]     ram_wmask,
    input  logic [8*BEAT_BYTES-1:0]   ram_rdata
);
    localparam int BEATS   = BYTE_NUM / BEAT_BYTES;
    localparam int OFF_W   = $clog2(BYTE_NUM);
    localparam int BEAT_SH = $clog2(BEATS);
    localparam int CNT_W   = (BEATS > 1) ? BEAT_SH : 1;
    localparam int WW      = 8 * BEAT_BYTES;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    line_resp_state_t          state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [8*BYTE_NUM-1:0]     line_q, line_d;
    logic [BYTE_NUM-1:0]       sel_q, sel_d;
    logic [8*BYTE_NUM-1:0]     rd_data_q, rd_data_d;
    logic                      ack_q, ack_d;
    logic                      ram_en_q, ram_en_d;
    logic                      ram_we_q, ram_we_d;
    logic [RAM_ADDR_SIZE-1:0]  ram_addr_q, ram_addr_d;
    logic [WW-1:0]             ram_wdata_q, ram_wdata_d;
    logic [BEAT_BYTES-1:0]     ram_wmask_q, ram_wmask_d;

    logic [RAM_ADDR_SIZE-1:0]  base;
    logic [CNT_W-1:0]          nxt;
    logic [CNT_W-1:0]          slot;
    logic [BEAT_BYTES-1:0]     nxt_mask;

    // Line index times BEATS; BEATS is a power of two so a shift suffices.
    assign base = RAM_ADDR_SIZE'((line.addr >> OFF_W) << BEAT_SH);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        sel_d       = sel_q;
        rd_data_d   = rd_data_q;
        ack_d       = 1'b0;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wmask_d = ram_wmask_q;
        nxt         = cnt_q + CNT_W'(1);
        slot        = (state_q == LR_DRAIN) ? LAST_BEAT : cnt_q - CNT_W'(1);
        nxt_mask    = sel_q[nxt*BEAT_BYTES +: BEAT_BYTES];

        case (state_q)
            LR_IDLE: begin
                if (line.wr_en || line.rd_en) begin
                    cnt_d      = '0;
                    line_d     = line.wr_data;
                    sel_d      = line.sel;
                    ram_addr_d = base;
                end
                // Write wins a conflict; a still-held rd_en is picked up after ack.
                if (line.wr_en) begin
                    state_d     = LR_WRITE;
                    ram_wdata_d = line.wr_data[WW-1:0];
                    ram_wmask_d = line.sel[BEAT_BYTES-1:0];
                    ram_en_d    = |line.sel[BEAT_BYTES-1:0];
                    ram_we_d    = |line.sel[BEAT_BYTES-1:0];
                end else if (line.rd_en) begin
                    state_d  = LR_READ;
                    ram_en_d = 1'b1;
                end
            end
            LR_READ: begin
                // Data for the strobe issued last cycle arrives now.
                if (cnt_q != '0) begin
                    rd_data_d[slot*WW +: WW] = ram_rdata;
                end
                if (cnt_q == LAST_BEAT) begin
                    state_d = LR_DRAIN;
                end else begin
                    cnt_d      = nxt;
                    ram_en_d   = 1'b1;
                    ram_addr_d = ram_addr_q + RAM_ADDR_SIZE'(1);
                end
            end
            LR_DRAIN: begin
                rd_data_d[slot*WW +: WW] = ram_rdata;
                state_d = LR_ACK;
                ack_d   = 1'b1;
            end
            LR_WRITE: begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = LR_ACK;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d       = nxt;
                    ram_addr_d  = ram_addr_q + RAM_ADDR_SIZE'(1);
                    ram_wdata_d = line_q[nxt*WW +: WW];
                    ram_wmask_d = nxt_mask;
                    ram_en_d    = |nxt_mask;
                    ram_we_d    = |nxt_mask;
                end
            end
            LR_ACK: begin
                state_d = LR_IDLE;
            end
            default: begin
                state_d = LR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= LR_IDLE;
            cnt_q       <= '0;
            line_q      <= '0;
            sel_q       <= '0;
            rd_data_q   <= '0;
            ack_q       <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wmask_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            sel_q       <= sel_d;
            rd_data_q   <= rd_data_d;
            ack_q       <= ack_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wmask_q <= ram_wmask_d;
        end
    end

    assign line.rd_data = rd_data_q;
    assign line.ack     = ack_q;
    assign ram_en       = ram_en_q;
    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign ram_wmask    = ram_wmask_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - self-checking bench for cache_mem_responder
module tb_cache_mem_responder;
    localparam int BEATS   = 4;
    localparam int SCHED_N = 512;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    cache_mem_responder_if #(.BYTE_NUM(8), .ADDR_SIZE(32)) line_if ();

    logic        ram_en, ram_we;
    logic [15:0] ram_addr, ram_wdata;
    logic [1:0]  ram_wmask;
    logic [15:0] ram_rdata = '0;

    cache_mem_responder #(
        .BYTE_NUM(8), .BEAT_BYTES(2), .ADDR_SIZE(32), .RAM_ADDR_SIZE(16)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .line     (line_if),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_wmask(ram_wmask),
        .ram_rdata(ram_rdata)
    );

    // Backing SRAM: 1-cycle read latency, byte-masked writes.
    logic [15:0] mem [0:255];
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) begin
                if (ram_wmask[0]) mem[ram_addr[7:0]][7:0]  <= ram_wdata[7:0];
                if (ram_wmask[1]) mem[ram_addr[7:0]][15:8] <= ram_wdata[15:8];
            end else begin
                ram_rdata <= mem[ram_addr[7:0]];
            end
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Expected per-cycle behaviour, filled in by the transaction model.
    bit          s_en   [SCHED_N];
    bit          s_we   [SCHED_N];
    bit          s_ack  [SCHED_N];
    bit          s_busy [SCHED_N];
    bit          s_rdv  [SCHED_N];
    logic [15:0] s_addr [SCHED_N];
    logic [15:0] s_wdata[SCHED_N];
    logic [1:0]  s_wmask[SCHED_N];
    logic [63:0] s_rdval[SCHED_N];
    logic [15:0] model_mem [0:255];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sched_write(input int c0, input logic [31:0] a,
                                       input logic [7:0] s, input logic [63:0] d);
        logic [15:0] b;
        logic [1:0]  m;
        int          c;
        b = 16'((a >> 3) * BEATS);
        for (int k = 0; k < BEATS; k++) begin
            m = s[k*2 +: 2];
            c = c0 + 1 + k;
            s_en[c]    = (m != 2'b00);
            s_we[c]    = 1'b1;
            s_addr[c]  = 16'(b + k);
            s_wdata[c] = d[k*16 +: 16];
            s_wmask[c] = m;
            if (m[0]) model_mem[8'(b + k)][7:0]  = d[k*16 +: 8];
            if (m[1]) model_mem[8'(b + k)][15:8] = d[k*16+8 +: 8];
        end
        s_ack[c0 + BEATS + 1] = 1'b1;
        return c0 + BEATS + 1;
    endfunction

    function automatic int sched_read(input int c0, input logic [31:0] a);
        logic [15:0] b;
        logic [63:0] rv;
        b = 16'((a >> 3) * BEATS);
        for (int k = 0; k < BEATS; k++) begin
            s_en[c0 + 1 + k]   = 1'b1;
            s_we[c0 + 1 + k]   = 1'b0;
            s_addr[c0 + 1 + k] = 16'(b + k);
            rv[k*16 +: 16]     = model_mem[8'(b + k)];
        end
        for (int c = c0 + 1; c <= c0 + BEATS + 1; c++) s_busy[c] = 1'b1;
        s_ack[c0 + BEATS + 2]   = 1'b1;
        s_rdv[c0 + BEATS + 2]   = 1'b1;
        s_rdval[c0 + BEATS + 2] = rv;
        return c0 + BEATS + 2;
    endfunction

    typedef struct {
        int          c;
        logic [15:0] a;
        logic [15:0] d;
        logic [1:0]  m;
    } wr_rec_t;
    wr_rec_t wlog[$];

    logic [63:0] model_rd = '0;
    int          ack_count = 0;
    int          last_ack_cyc = -1;

    // Per-cycle compare, away from the active edge.
    always @(negedge clock) begin
        if (!reset_n) model_rd = '0;
        else if (s_rdv[cyc]) model_rd = s_rdval[cyc];
        if (cyc < SCHED_N) begin
            check("ack", line_if.ack, s_ack[cyc]);
            check("ram_en", ram_en, s_en[cyc]);
            if (s_en[cyc]) begin
                check("ram_we", ram_we, s_we[cyc]);
                check("ram_addr", ram_addr, s_addr[cyc]);
                if (s_we[cyc]) begin
                    check("ram_wdata", ram_wdata, s_wdata[cyc]);
                    check("ram_wmask", ram_wmask, s_wmask[cyc]);
                end
            end
            if (!s_busy[cyc]) check("rd_data", line_if.rd_data, model_rd);
        end
        if (line_if.ack === 1'b1) begin
            ack_count++;
            last_ack_cyc = cyc;
        end
        if (ram_en === 1'b1 && ram_we === 1'b1)
            wlog.push_back('{c: cyc, a: ram_addr, d: ram_wdata, m: ram_wmask});
    end

    task automatic step_to(input int target);
        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [7:0] s, input logic [63:0] d);
        line_if.rd_en   = rd;
        line_if.wr_en   = wr;
        line_if.addr    = a;
        line_if.sel     = s;
        line_if.wr_data = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]       = 16'(16'h1000 + i);
            model_mem[i] = 16'(16'h1000 + i);
        end
    end

    initial begin
        int c0, c1, a, r, k0, n0;
        drive(1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
        repeat (3) @(posedge clock);
        #1;
        check("reset_ram_en", ram_en, 1'b0);
        check("reset_ram_we", ram_we, 1'b0);
        check("reset_ack", line_if.ack, 1'b0);
        check("reset_rd_data", line_if.rd_data, 64'h0);
        check("reset_ram_addr", ram_addr, 16'h0);
        check("reset_ram_wdata_mask", {ram_wdata, ram_wmask}, 18'h0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Refill of line 3.
        c0 = cyc;
        drive(1'b1, 1'b0, 32'h18, 8'h00, 64'h0);
        a = sched_read(c0, 32'h18);
        step_to(a + 1);
        drive(1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
        check("refill_line", line_if.rd_data, 64'h100F_100E_100D_100C);
        check("refill_ack_cycle", last_ack_cyc - c0, 6);

        // Full write-back of line 1.
        c0 = cyc;
        drive(1'b0, 1'b1, 32'h08, 8'hFF, 64'h8877_6655_4433_2211);
        a = sched_write(c0, 32'h08, 8'hFF, 64'h8877_6655_4433_2211);
        step_to(a + 1);
        drive(1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
        check("full_wb_ack_cycle", last_ack_cyc - c0, 5);
        check("full_wb_mem", {mem[7], mem[6], mem[5], mem[4]}, 64'h8877_6655_4433_2211);

        // Sparse write: only beat 1 is enabled.
        n0 = wlog.size();
        c0 = cyc;
        drive(1'b0, 1'b1, 32'h08, 8'h0C, 64'h8877_6655_4433_2211);
        a = sched_write(c0, 32'h08, 8'h0C, 64'h8877_6655_4433_2211);
        step_to(a + 1);
        drive(1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
        check("sparse_write_count", wlog.size() - n0, 1);
        if (wlog.size() > n0) begin
            check("sparse_write_cycle", wlog[n0].c - c0, 2);
            check("sparse_write_beat", {wlog[n0].a, wlog[n0].d, wlog[n0].m}, {16'd5, 16'h4433, 2'b11});
        end
        check("sparse_ack_cycle", last_ack_cyc - c0, 5);

        // Back-to-back write-back then refill of the same line.
        k0 = ack_count;
        c0 = cyc;
        drive(1'b0, 1'b1, 32'h10, 8'hF0, 64'hDDDD_CCCC_BBBB_AAAA);
        a = sched_write(c0, 32'h10, 8'hF0, 64'hDDDD_CCCC_BBBB_AAAA);
        step_to(a + 1);
        c1 = cyc;
        drive(1'b1, 1'b0, 32'h10, 8'h00, 64'h0);
        r = sched_read(c1, 32'h10);
        step_to(r + 1);
        drive(1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
        check("b2b_ack_pulses", ack_count - k0, 2);
        check("b2b_read_ack_cycle", last_ack_cyc - c1, 6);
        check("b2b_line", line_if.rd_data, 64'hDDDD_CCCC_1009_1008);

        // rd_en and wr_en together: write first, then the held read.
        c0 = cyc;
        drive(1'b1, 1'b1, 32'h20, 8'hFF, 64'h0123_4567_89AB_CDEF);
        a = sched_write(c0, 32'h20, 8'hFF, 64'h0123_4567_89AB_CDEF);
        step_to(a + 1);
        line_if.wr_en = 1'b0;
        r = sched_read(a + 1, 32'h20);
        step_to(r + 1);
        drive(1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
        check("conflict_line", line_if.rd_data, 64'h0123_4567_89AB_CDEF);
        check("conflict_mem", mem[16], 16'hCDEF);

        // Abort a refill in its third cycle.
        k0 = ack_count;
        c0 = cyc;
        drive(1'b1, 1'b0, 32'h18, 8'h00, 64'h0);
        a = sched_read(c0, 32'h18);
        step_to(c0 + 3);
        for (int c = c0 + 3; c < c0 + 12; c++) begin
            s_en[c] = 1'b0; s_ack[c] = 1'b0; s_busy[c] = 1'b0; s_rdv[c] = 1'b0;
        end
        reset_n = 1'b0;
        line_if.rd_en = 1'b0;
        #2;
        check("abort_ram_en", ram_en, 1'b0);
        check("abort_ack", line_if.ack, 1'b0);
        check("abort_rd_data", line_if.rd_data, 64'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step_to(cyc + 8);
        check("abort_no_ack", ack_count - k0, 0);

        // Normal refill after the abort.
        c0 = cyc;
        drive(1'b1, 1'b0, 32'h00, 8'h00, 64'h0);
        a = sched_read(c0, 32'h00);
        step_to(a + 1);
        drive(1'b0, 1'b0, 32'h0, 8'h0, 64'h0);
        check("post_reset_line", line_if.rd_data, 64'h1003_1002_1001_1000);
        step_to(cyc + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Memory-side responder for the cache line interface: serves line refills (`rd_en`) and write-backs (`wr_en`) issued by the cache controller.
- Splits each BYTE_NUM-byte line into BEATS = BYTE_NUM/BEAT_BYTES beats on a narrow synchronous SRAM with 1-cycle read latency.
- Returns a single-cycle `ack`, completing the cache's `mem_ack` handshake.
- Sits between the cache and the backing RAM.

Parameters:
- BYTE_NUM, 8, line width in bytes; matches the cache's BYTE_NUM.
- BEAT_BYTES, 2, SRAM word width in bytes; BYTE_NUM must be a multiple, power of two.
- ADDR_SIZE, 32, byte address width of the line interface.
- RAM_ADDR_SIZE, 16, SRAM word address width.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rd_en  input  1  line read (refill) request; held until ack.
- wr_en  input  1  line write (write-back) request; held until ack.
- sel  input  BYTE_NUM  byte enables for writes; ignored for reads.
- addr  input  ADDR_SIZE  byte address; low log2(BYTE_NUM) bits ignored.
- wr_data  input  8*BYTE_NUM  write-back line.
- rd_data  output  8*BYTE_NUM  refill line; valid in the ack cycle, held until the next read completes.
- ack  output  1  one-cycle completion pulse.
- ram_en  output  1  SRAM access strobe.
- ram_we  output  1  SRAM write strobe; valid when ram_en=1.
- ram_addr  output  RAM_ADDR_SIZE  SRAM word address.
- ram_wdata  output  8*BEAT_BYTES  SRAM write data.
- ram_wmask  output  BEAT_BYTES  SRAM byte write mask.
- ram_rdata  input  8*BEAT_BYTES  SRAM read data; valid the cycle after a read strobe.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=Idle, ack=0, ram_en=0, ram_we=0.
  - ram_addr, ram_wdata, ram_wmask=0; rd_data=0; beat counter=0.
- Reset mid-operation: the transfer is aborted with no ack. Partial SRAM writes are not undone.
- Request sampling, Idle state only. Cycle 0 is the first cycle Idle sees rd_en or wr_en high.
  - Latch addr, sel, wr_data; go to Read or Write.
  - Base = line index (addr >> log2 BYTE_NUM) * BEATS, truncated to RAM_ADDR_SIZE.
  - rd_en and wr_en both high: write wins; rd_en is re-sampled after ack if still high.
- Beat mapping: beat k covers bytes k*BEAT_BYTES..(k+1)*BEAT_BYTES-1 (little-endian), at ram_addr = base+k.
- Read state, cycles 1..BEATS:
  - ram_en=1, ram_we=0, ram_addr=base+k for k=0..BEATS-1, one per cycle, no bubbles.
  - Each beat's ram_rdata is captured into rd_data slot k one cycle later.
- Drain state, cycle BEATS+1: captures the last beat; ram_en=0.
- Ack state: ack=1 for exactly one cycle, then Idle. Read ack is in cycle BEATS+2 (6 for defaults).
- Write state, cycles 1..BEATS:
  - Beat k drives ram_wdata = line slice k and ram_wmask = sel slice k.
  - ram_en=ram_we=1 only if that mask slice is nonzero; zero-mask beats are skipped but still take one cycle.
  - Then Ack. Write ack is in cycle BEATS+1 (5 for defaults).
- Deassertion of rd_en/wr_en mid-transfer is ignored: the transfer completes and ack still pulses.
- Idle accepts a new request in the cycle after ack; no dead cycle. This supports back-to-back write-back then refill.
- rd_data is not disturbed by writes or aborted reads beyond the slots already captured.
- Beat counter is log2(BEATS) bits, ≥1 bit; it resets to 0 on every entry to Read/Write.

Decomposition:
- Add `line_resp_state_t` (Idle, Read, Drain, Write, Ack) to `cache_pkg`, beside `cache_state_t`.
- Derived localparams (BEATS, offset width) stay local.
- No sub-module: the beat counter and line assembly register are inline.

Test Plan:
- Test bench setup: defaults; RAM word i preloaded with 16'h1000+i.
- Refill: rd_en, addr=0x18 → ram_addr 12,13,14,15 in cycles 1-4; ack in cycle 6 only; rd_data=64'h100F_100E_100D_100C.
- Full write-back: wr_en, addr=0x08, wr_data=64'h8877_6655_4433_2211, sel=8'hFF → writes {4:2211, 5:4433, 6:6655, 7:8877}, mask 2'b11; ack in cycle 5.
- Sparse write: sel=8'h0C, same addr → single SRAM write at cycle 2, addr 5, data 16'h4433, mask 2'b11; ack still in cycle 5.
- Back-to-back: write-back acked, rd_en high the next cycle → read starts immediately; ack 6 cycles later; exactly two ack pulses.
- Reset and conflict:
  - reset_n low in cycle 3 of a read → ram_en and ack 0 immediately; Idle after release; no ack.
  - rd_en=wr_en=1 → write executed first.
